indirect_coe_ctrl: RTL and testbench

INDIRECT_COE_CTRL -- requirements
Module: indirect_coe_ctrl

---
 rtl/indirect_coe_ctrl_pkg.sv | 25 ++
 rtl/indirect_coe_ctrl_credit.sv | 64 ++++++
 rtl/indirect_coe_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_indirect_coe_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/indirect_coe_ctrl_pkg.sv
// rtl/indirect_coe_ctrl_pkg.sv - shared widths, FSM state type and helpers for indirect_coe_ctrl
//
// Purpose: holds the point-cloud and intrinsic widths plus the controller state
// enum, so the controller, its credit counter and the bench agree on them.
package RgbdVoConfigPk;

  localparam int CLOUD_BW = 16;
  localparam int FX_BW    = 18;
  localparam int FY_BW    = 18;
  localparam int CX_BW    = 16;
  localparam int CY_BW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  // A point is projectable only when its depth is strictly positive (two's complement).
  function automatic logic z_is_positive(input logic [CLOUD_BW-1:0] z);
    return !z[CLOUD_BW-1] && (z != '0);
  endfunction

endpackage

// File: rtl/indirect_coe_ctrl_credit.sv
// rtl/indirect_coe_ctrl_credit.sv - in-flight and FIFO occupancy counters with credit compare
//
// Purpose: tracks points issued but not yet returned (inflight) and results held
// in the downstream FIFO (fifo_cnt); grants credit while their sum is below depth.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_issue           one point issued to the datapath this cycle
//   i_dp_valid        one datapath result written into the FIFO
//   i_fifo_pop        consumer pops one FIFO entry
//   o_credit          inflight + fifo_cnt < FIFO_DEPTH
//   o_inflight_zero   nothing outstanding in the datapath
//   o_err             single-cycle protocol error (underflow/overflow)
module CreditCounter #(
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_issue,
  input  logic i_dp_valid,
  input  logic i_fifo_pop,
  output logic o_credit,
  output logic o_inflight_zero,
  output logic o_err
);

  localparam int            SW      = CW + 1;
  localparam logic [SW-1:0] DEPTH_W = SW'(FIFO_DEPTH);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [SW-1:0] inflight_nx, fifo_nx;
  logic          dv_ok, pop_ok, inflight_ovf, fifo_ovf;

  always_comb begin
    // A result with nothing outstanding, or a pop of an empty FIFO, is not
    // allowed to move the counter below zero.
    dv_ok        = i_dp_valid && (inflight_q != '0);
    pop_ok       = i_fifo_pop && (fifo_cnt_q != '0);
    // Net change so that simultaneous events never lose a count.
    inflight_nx  = {1'b0, inflight_q} + SW'(i_issue) - SW'(dv_ok);
    fifo_nx      = {1'b0, fifo_cnt_q} + SW'(i_dp_valid) - SW'(pop_ok);
    inflight_ovf = inflight_nx > DEPTH_W;
    fifo_ovf     = fifo_nx > DEPTH_W;
    inflight_d   = inflight_ovf ? inflight_q : inflight_nx[CW-1:0];
    fifo_cnt_d   = fifo_ovf ? fifo_cnt_q : fifo_nx[CW-1:0];
    o_err        = (i_dp_valid && !dv_ok) || (i_fifo_pop && !pop_ok) ||
                   inflight_ovf || fifo_ovf;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign o_credit        = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_W;
  assign o_inflight_zero = (inflight_q == '0);

endmodule

// File: rtl/indirect_coe_ctrl.sv
// rtl/indirect_coe_ctrl.sv - frame controller issuing cloud points to the indirect-coefficient datapath
//
// Purpose: accepts a frame of points, drops points with non-positive depth,
// issues the rest to a fixed-latency datapath under FIFO credit, shadows the
// intrinsics for the whole frame and reports done/abort/skip/error status.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_start, i_abort             frame start / abort pulses
//   i_num_pts, i_fx..i_cy        frame length and intrinsics, sampled on start
//   i_pt_valid/o_pt_ready        source point handshake, i_cloud_x/y/z payload
//   o_dp_valid, o_dp_cloud_x/y/z issue to datapath
//   o_fx..o_cy                   shadowed intrinsics
//   i_dp_valid, i_fifo_pop       datapath result into FIFO, consumer pop
//   o_busy, o_done, o_aborted    frame status
//   o_skip_cnt, o_err            skipped points, sticky protocol error
module indirect_coe_ctrl
  import RgbdVoConfigPk::*;
#(
  parameter int LATENCY    = 13,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_BW     = 20
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [CNT_BW-1:0]   i_num_pts,
  input  logic [FX_BW-1:0]    i_fx,
  input  logic [FY_BW-1:0]    i_fy,
  input  logic [CX_BW-1:0]    i_cx,
  input  logic [CY_BW-1:0]    i_cy,
  input  logic                i_pt_valid,
  output logic                o_pt_ready,
  input  logic [CLOUD_BW-1:0] i_cloud_x,
  input  logic [CLOUD_BW-1:0] i_cloud_y,
  input  logic [CLOUD_BW-1:0] i_cloud_z,
  output logic                o_dp_valid,
  output logic [CLOUD_BW-1:0] o_dp_cloud_x,
  output logic [CLOUD_BW-1:0] o_dp_cloud_y,
  output logic [CLOUD_BW-1:0] o_dp_cloud_z,
  output logic [FX_BW-1:0]    o_fx,
  output logic [FY_BW-1:0]    o_fy,
  output logic [CX_BW-1:0]    o_cx,
  output logic [CY_BW-1:0]    o_cy,
  input  logic                i_dp_valid,
  input  logic                i_fifo_pop,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_aborted,
  output logic [CNT_BW-1:0]   o_skip_cnt,
  output logic                o_err
);

  // Credit must cover every result the datapath can have in flight.
  if (FIFO_DEPTH < LATENCY + 1) begin : g_depth_check
    $error("FIFO_DEPTH must be at least LATENCY+1");
  end

  ctrl_state_e         state_q, state_d;
  logic [CNT_BW-1:0]   num_pts_q, num_pts_d;
  logic [CNT_BW-1:0]   consumed_q, consumed_d;
  logic [CNT_BW-1:0]   skip_cnt_q, skip_cnt_d;
  logic                aborted_q, aborted_d;
  logic                err_q, err_d;
  logic [FX_BW-1:0]    fx_q, fx_d;
  logic [FY_BW-1:0]    fy_q, fy_d;
  logic [CX_BW-1:0]    cx_q, cx_d;
  logic [CY_BW-1:0]    cy_q, cy_d;
  logic                dp_valid_q, dp_valid_d;
  logic [CLOUD_BW-1:0] dp_x_q, dp_x_d, dp_y_q, dp_y_d, dp_z_q, dp_z_d;

  logic pt_ready, hs, issue;
  logic credit, inflight_zero, cc_err;

  CreditCounter #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_issue         (issue),
    .i_dp_valid      (i_dp_valid),
    .i_fifo_pop      (i_fifo_pop),
    .o_credit        (credit),
    .o_inflight_zero (inflight_zero),
    .o_err           (cc_err)
  );

  always_comb begin
    state_d    = state_q;
    num_pts_d  = num_pts_q;
    consumed_d = consumed_q;
    skip_cnt_d = skip_cnt_q;
    aborted_d  = aborted_q;
    err_d      = err_q | cc_err;
    fx_d       = fx_q;
    fy_d       = fy_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    dp_valid_d = 1'b0;
    dp_x_d     = dp_x_q;
    dp_y_d     = dp_y_q;
    dp_z_d     = dp_z_q;
    pt_ready   = 1'b0;
    hs         = 1'b0;
    issue      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          num_pts_d  = i_num_pts;
          consumed_d = '0;
          skip_cnt_d = '0;
          aborted_d  = 1'b0;
          fx_d       = i_fx;
          fy_d       = i_fy;
          cx_d       = i_cx;
          cy_d       = i_cy;
          state_d    = (i_num_pts == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        pt_ready = credit && (consumed_q < num_pts_q);
        hs       = i_pt_valid && pt_ready;
        if (hs) begin
          consumed_d = consumed_q + CNT_BW'(1);
          if (z_is_positive(i_cloud_z)) begin
            // Inflight is charged on the handshake, so the credit compare
            // already accounts for the issue registered for next cycle.
            issue      = 1'b1;
            dp_valid_d = 1'b1;
            dp_x_d     = i_cloud_x;
            dp_y_d     = i_cloud_y;
            dp_z_d     = i_cloud_z;
          end else begin
            skip_cnt_d = skip_cnt_q + CNT_BW'(1);
          end
        end
        // An abort coinciding with a handshake still consumes that point.
        if (i_abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (consumed_d == num_pts_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_zero && !dp_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      num_pts_q  <= '0;
      consumed_q <= '0;
      skip_cnt_q <= '0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
      fx_q       <= '0;
      fy_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      dp_valid_q <= 1'b0;
      dp_x_q     <= '0;
      dp_y_q     <= '0;
      dp_z_q     <= '0;
    end else begin
      state_q    <= state_d;
      num_pts_q  <= num_pts_d;
      consumed_q <= consumed_d;
      skip_cnt_q <= skip_cnt_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      dp_valid_q <= dp_valid_d;
      dp_x_q     <= dp_x_d;
      dp_y_q     <= dp_y_d;
      dp_z_q     <= dp_z_d;
    end
  end

  assign o_pt_ready   = pt_ready;
  assign o_dp_valid   = dp_valid_q;
  assign o_dp_cloud_x = dp_x_q;
  assign o_dp_cloud_y = dp_y_q;
  assign o_dp_cloud_z = dp_z_q;
  assign o_fx         = fx_q;
  assign o_fy         = fy_q;
  assign o_cx         = cx_q;
  assign o_cy         = cy_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_aborted    = aborted_q;
  assign o_skip_cnt   = skip_cnt_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_indirect_coe_ctrl.sv
// tb/tb_indirect_coe_ctrl.sv - directed self-checking bench for indirect_coe_ctrl
module tb_indirect_coe_ctrl;
  import RgbdVoConfigPk::*;

  localparam int LATENCY    = 13;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_BW     = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                i_start = 1'b0;
  logic [CNT_BW-1:0]   i_num_pts = '0;
  logic [FX_BW-1:0]    i_fx = '0;
  logic [FY_BW-1:0]    i_fy = '0;
  logic [CX_BW-1:0]    i_cx = '0;
  logic [CY_BW-1:0]    i_cy = '0;
  logic                i_abort;
  logic                i_pt_valid;
  logic                o_pt_ready;
  logic [CLOUD_BW-1:0] i_cloud_x, i_cloud_y, i_cloud_z;
  logic                o_dp_valid;
  logic [CLOUD_BW-1:0] o_dp_cloud_x, o_dp_cloud_y, o_dp_cloud_z;
  logic [FX_BW-1:0]    o_fx;
  logic [FY_BW-1:0]    o_fy;
  logic [CX_BW-1:0]    o_cx;
  logic [CY_BW-1:0]    o_cy;
  logic                i_dp_valid, i_fifo_pop;
  logic                o_busy, o_done, o_aborted, o_err;
  logic [CNT_BW-1:0]   o_skip_cnt;

  // Bench-side controls
  logic src_en = 1'b0, auto_pop = 1'b0, pop_man = 1'b0, man_abort = 1'b0;
  logic spur_dv = 1'b0, mon_clr = 1'b0;
  int   abort_at = 0;
  logic [CLOUD_BW-1:0] z_tab [0:63];

  // Datapath and consumer models
  logic [LATENCY-1:0] pipe_q = '0;
  logic               pop_auto_q = 1'b0;
  always @(posedge clk) begin
    pipe_q     <= {pipe_q[LATENCY-2:0], o_dp_valid};
    pop_auto_q <= auto_pop & i_dp_valid;
  end
  assign i_dp_valid = pipe_q[LATENCY-1] | spur_dv;
  assign i_fifo_pop = pop_auto_q | pop_man;

  // Source model and monitor
  int hs_cnt = 0, issue_cnt = 0, done_cnt = 0, x_sum = 0, bad_z = 0;
  int cyc = 0, last_issue_cyc = 0, done_cyc = 0;
  wire hs = i_pt_valid & o_pt_ready;
  assign i_pt_valid = src_en;
  assign i_cloud_x  = CLOUD_BW'(hs_cnt);
  assign i_cloud_y  = CLOUD_BW'(hs_cnt * 2);
  assign i_cloud_z  = z_tab[hs_cnt];
  assign i_abort    = man_abort | ((abort_at != 0) && hs && (hs_cnt == abort_at - 1));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      hs_cnt <= 0; issue_cnt <= 0; done_cnt <= 0; x_sum <= 0; bad_z <= 0;
    end else begin
      if (hs) hs_cnt <= hs_cnt + 1;
      if (o_dp_valid) begin
        issue_cnt      <= issue_cnt + 1;
        last_issue_cyc <= cyc;
        x_sum          <= x_sum + int'(o_dp_cloud_x);
        if ($signed(o_dp_cloud_z) <= 0) bad_z <= bad_z + 1;
      end
      if (o_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  indirect_coe_ctrl #(
    .LATENCY (LATENCY), .FIFO_DEPTH (FIFO_DEPTH), .CNT_BW (CNT_BW)
  ) dut (
    .i_clk (clk), .i_rst (rst), .i_start (i_start), .i_abort (i_abort),
    .i_num_pts (i_num_pts), .i_fx (i_fx), .i_fy (i_fy), .i_cx (i_cx), .i_cy (i_cy),
    .i_pt_valid (i_pt_valid), .o_pt_ready (o_pt_ready),
    .i_cloud_x (i_cloud_x), .i_cloud_y (i_cloud_y), .i_cloud_z (i_cloud_z),
    .o_dp_valid (o_dp_valid), .o_dp_cloud_x (o_dp_cloud_x),
    .o_dp_cloud_y (o_dp_cloud_y), .o_dp_cloud_z (o_dp_cloud_z),
    .o_fx (o_fx), .o_fy (o_fy), .o_cx (o_cx), .o_cy (o_cy),
    .i_dp_valid (i_dp_valid), .i_fifo_pop (i_fifo_pop),
    .o_busy (o_busy), .o_done (o_done), .o_aborted (o_aborted),
    .o_skip_cnt (o_skip_cnt), .o_err (o_err)
  );

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_z(input int v);
    for (int i = 0; i < 64; i++) z_tab[i] = CLOUD_BW'(v);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_frame(input int n, input int fx);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr   = 1'b0;
    i_num_pts = CNT_BW'(n);
    i_fx      = FX_BW'(fx);
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    i_fy = FY_BW'(7); i_cx = CX_BW'(320); i_cy = CY_BW'(240);
    fill_z(100);

    // Reset state
    wait_cycles(3);
    check_val("rst_busy",     o_busy,     0);
    check_val("rst_ready",    o_pt_ready, 0);
    check_val("rst_dp_valid", o_dp_valid, 0);
    check_val("rst_done",     o_done,     0);
    check_val("rst_aborted",  o_aborted,  0);
    check_val("rst_err",      o_err,      0);
    check_val("rst_skip",     o_skip_cnt, 0);
    check_val("rst_fx",       o_fx,       0);
    rst = 1'b0;
    wait_cycles(2);
    src_en = 1'b1;

    // 20 points, all valid, consumer pops immediately; intrinsics change mid-frame
    auto_pop = 1'b1;
    start_frame(20, 111);
    check_val("r21_busy", o_busy, 1);
    wait_cycles(5);
    i_fx = FX_BW'(999);
    wait_cycles(1);
    check_val("r21_fx_mid", o_fx, 111);
    wait_done("r21", 300);
    check_val("r21_issues",  issue_cnt, 20);
    check_val("r21_done_lat", 64'(done_cyc - last_issue_cyc), 64'(LATENCY + 2));
    check_val("r21_skip",    o_skip_cnt, 0);
    check_val("r21_busy_end", o_busy, 0);
    check_val("r21_err",     o_err, 0);
    check_val("r21_fx_end",  o_fx, 111);
    check_val("r21_xsum",    x_sum, 190);

    // 8 points, indices 2 and 5 have z=0 and z=-4
    fill_z(100);
    z_tab[2] = CLOUD_BW'(0);
    z_tab[5] = CLOUD_BW'(-4);
    start_frame(8, 222);
    check_val("r22_fx_new", o_fx, 222);
    wait_done("r22", 200);
    check_val("r22_issues", issue_cnt, 6);
    check_val("r22_skip",   o_skip_cnt, 2);
    check_val("r22_xsum",   x_sum, 21);
    check_val("r22_bad_z",  bad_z, 0);
    check_val("r22_err",    o_err, 0);
    fill_z(100);

    // Consumer never pops: credit limits issue to FIFO_DEPTH
    auto_pop = 1'b0;
    start_frame(40, 5);
    wait_cycles(45);
    check_val("r23_issues_full", issue_cnt, FIFO_DEPTH);
    check_val("r23_ready_full",  o_pt_ready, 0);
    pop_man = 1'b1;
    @(negedge clk);
    pop_man = 1'b0;
    wait_cycles(30);
    check_val("r23_issues_pop1", issue_cnt, FIFO_DEPTH + 1);
    check_val("r23_ready_pop1",  o_pt_ready, 0);
    man_abort = 1'b1;
    @(negedge clk);
    man_abort = 1'b0;
    wait_done("r23", 50);
    check_val("r23_aborted", o_aborted, 1);
    pop_man = 1'b1;
    wait_cycles(FIFO_DEPTH);
    pop_man = 1'b0;
    @(negedge clk);
    check_val("r23_err", o_err, 0);

    // Abort on the 5th handshake of 30
    auto_pop = 1'b1;
    abort_at = 5;
    start_frame(30, 5);
    wait_done("r24", 200);
    abort_at = 0;
    check_val("r24_issues",  issue_cnt, 5);
    check_val("r24_aborted", o_aborted, 1);
    check_val("r24_err",     o_err, 0);

    // Zero-point frame: next start clears o_aborted, done within 3 cycles
    start_frame(0, 5);
    check_val("r25_aborted_clr", o_aborted, 0);
    n = 0;
    while (!o_done && n < 3) begin
      @(negedge clk);
      n++;
    end
    check_val("r25_zero_done", o_done, 1);
    @(negedge clk);
    check_val("r25_zero_issues", issue_cnt, 0);
    check_val("r25_zero_idle",   o_busy, 0);

    // Spurious result in IDLE sets a sticky error
    spur_dv = 1'b1;
    @(negedge clk);
    spur_dv = 1'b0;
    @(negedge clk);
    check_val("r26_err_set", o_err, 1);
    start_frame(0, 5);
    wait_done("r26", 10);
    check_val("r26_err_held", o_err, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("r26_err_rst", o_err, 0);
    rst = 1'b0;
    wait_cycles(2);

    // Reset mid-frame: late results raise the error after release
    start_frame(10, 5);
    wait_cycles(5);
    check_val("r18_issued_before_rst", 64'(issue_cnt > 0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("r18_busy_after_rst", o_busy, 0);
    check_val("r18_err_after_rst",  o_err, 0);
    wait_cycles(25);
    check_val("r18_err_late", o_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
